// File: rtl/wdt_intr_ctrl.sv
// Watchdog interrupt/status controller: sticky W1C timeout status, maskable interrupts,
// serviced pulses back to the timer core, and the cascade-mode fatal -> NMI sequencer.
module wdt_intr_ctrl #(
    parameter int NMI_DLY_W = 8
) (
    input  logic                 clk,
    input  logic                 cptra_rst_b,
    input  logic                 t1_timeout,
    input  logic                 t2_timeout,
    input  logic                 fatal_timeout,
    input  logic                 timer2_en,
    input  logic                 intr_en_t1,
    input  logic                 intr_en_t2,
    input  logic                 sts_clr_t1,
    input  logic                 sts_clr_t2,
    input  logic [NMI_DLY_W-1:0] nmi_delay,
    output logic                 t1_sts,
    output logic                 t2_sts,
    output logic                 t1_intr,
    output logic                 t2_intr,
    output logic                 wdt_timer1_timeout_serviced,
    output logic                 wdt_timer2_timeout_serviced,
    output logic                 fatal_err,
    output logic                 nmi,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        NMI_WAIT = 2'd1,
        FATAL    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NMI_DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic                 fatal_err_d, nmi_d;
    logic                 t1_q, t2_q, fatal_q;
    logic                 t1_rise, t2_rise, fatal_rise;
    logic                 is_idle;

    // History flops reset low so a level already high at reset release counts as an edge.
    assign t1_rise    = t1_timeout & ~t1_q;
    assign t2_rise    = t2_timeout & ~t2_q;
    assign fatal_rise = fatal_timeout & ~fatal_q;
    assign is_idle    = (state_q == IDLE);

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            t1_q    <= 1'b0;
            t2_q    <= 1'b0;
            fatal_q <= 1'b0;
            t1_sts  <= 1'b0;
            t2_sts  <= 1'b0;
            wdt_timer1_timeout_serviced <= 1'b0;
            wdt_timer2_timeout_serviced <= 1'b0;
        end else begin
            t1_q    <= t1_timeout;
            t2_q    <= t2_timeout;
            fatal_q <= fatal_timeout;
            // A new timeout edge takes priority over a same-cycle firmware clear.
            t1_sts  <= t1_rise | (t1_sts & ~sts_clr_t1);
            t2_sts  <= (t2_rise & timer2_en) | (t2_sts & ~sts_clr_t2);
            wdt_timer1_timeout_serviced <= sts_clr_t1 & t1_sts & ~t1_rise & is_idle;
            wdt_timer2_timeout_serviced <= sts_clr_t2 & t2_sts & ~t2_rise & is_idle;
        end
    end

    assign t1_intr = t1_sts & intr_en_t1;
    assign t2_intr = t2_sts & intr_en_t2;

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            state_q   <= IDLE;
            dly_cnt_q <= '0;
            fatal_err <= 1'b0;
            nmi       <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
            fatal_err <= fatal_err_d;
            nmi       <= nmi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dly_cnt_d   = dly_cnt_q;
        fatal_err_d = fatal_err;
        nmi_d       = nmi;
        case (state_q)
            IDLE: begin
                if (fatal_rise) begin
                    fatal_err_d = 1'b1;
                    if (nmi_delay == '0) begin
                        state_d = FATAL;
                        nmi_d   = 1'b1;
                    end else begin
                        state_d   = NMI_WAIT;
                        dly_cnt_d = nmi_delay;
                    end
                end
            end
            NMI_WAIT: begin
                // Counter is at least 1 here, so it leaves this state before it could wrap.
                dly_cnt_d = dly_cnt_q - NMI_DLY_W'(1);
                if (dly_cnt_q == NMI_DLY_W'(1)) begin
                    state_d = FATAL;
                    nmi_d   = 1'b1;
                end
            end
            FATAL:   state_d = FATAL;
            default: state_d = IDLE;
        endcase
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_wdt_intr_ctrl.sv
// Self-checking bench for wdt_intr_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an event-level reference model.
module tb_wdt_intr_ctrl;

    logic       clk;
    logic       cptra_rst_b;
    logic       t1_timeout, t2_timeout, fatal_timeout;
    logic       timer2_en, intr_en_t1, intr_en_t2;
    logic       sts_clr_t1, sts_clr_t2;
    logic [7:0] nmi_delay;
    logic       t1_sts, t2_sts, t1_intr, t2_intr;
    logic       srv1, srv2, fatal_err, nmi;
    logic [1:0] fsm_state;

    int checks   = 0;
    int failures = 0;

    wdt_intr_ctrl #(.NMI_DLY_W(8)) dut (
        .clk                         (clk),
        .cptra_rst_b                 (cptra_rst_b),
        .t1_timeout                  (t1_timeout),
        .t2_timeout                  (t2_timeout),
        .fatal_timeout               (fatal_timeout),
        .timer2_en                   (timer2_en),
        .intr_en_t1                  (intr_en_t1),
        .intr_en_t2                  (intr_en_t2),
        .sts_clr_t1                  (sts_clr_t1),
        .sts_clr_t2                  (sts_clr_t2),
        .nmi_delay                   (nmi_delay),
        .t1_sts                      (t1_sts),
        .t2_sts                      (t2_sts),
        .t1_intr                     (t1_intr),
        .t2_intr                     (t2_intr),
        .wdt_timer1_timeout_serviced (srv1),
        .wdt_timer2_timeout_serviced (srv2),
        .fatal_err                   (fatal_err),
        .nmi                         (nmi),
        .fsm_state                   (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: events are tracked as facts ("a fatal edge happened at cycle N
    // with delay D") and the outputs are derived from those facts.
    bit m_sts1, m_sts2, m_srv1, m_srv2, m_fseen;
    bit m_p1, m_p2, m_pf;
    int cyc, m_fcyc, m_fdly;

    task automatic model_reset();
        m_sts1 = 0; m_sts2 = 0; m_srv1 = 0; m_srv2 = 0; m_fseen = 0;
        m_p1 = 0; m_p2 = 0; m_pf = 0;
        m_fcyc = 0; m_fdly = 0;
    endtask

    function automatic bit m_nmi();
        return m_fseen && ((cyc - m_fcyc) >= m_fdly);
    endfunction

    function automatic int m_state();
        if (!m_fseen) return 0;
        return m_nmi() ? 2 : 1;
    endfunction

    task automatic model_edge();
        bit r1, r2, rf, idle;
        cyc++;
        if (!cptra_rst_b) begin
            model_reset();
            return;
        end
        r1   = t1_timeout && !m_p1;
        r2   = t2_timeout && !m_p2;
        rf   = fatal_timeout && !m_pf;
        idle = !m_fseen;
        m_srv1 = sts_clr_t1 && m_sts1 && !r1 && idle;
        m_srv2 = sts_clr_t2 && m_sts2 && !r2 && idle;
        m_sts1 = r1 || (m_sts1 && !sts_clr_t1);
        m_sts2 = (r2 && timer2_en) || (m_sts2 && !sts_clr_t2);
        if (idle && rf) begin
            m_fseen = 1;
            m_fcyc  = cyc;
            m_fdly  = int'(nmi_delay);
        end
        m_p1 = t1_timeout;
        m_p2 = t2_timeout;
        m_pf = fatal_timeout;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("t1_sts",    32'(t1_sts),    32'(m_sts1));
        chk("t2_sts",    32'(t2_sts),    32'(m_sts2));
        chk("t1_intr",   32'(t1_intr),   32'(m_sts1 && intr_en_t1));
        chk("t2_intr",   32'(t2_intr),   32'(m_sts2 && intr_en_t2));
        chk("srv1",      32'(srv1),      32'(m_srv1));
        chk("srv2",      32'(srv2),      32'(m_srv2));
        chk("fatal_err", 32'(fatal_err), 32'(m_fseen));
        chk("nmi",       32'(nmi),       32'(m_nmi()));
        chk("fsm_state", 32'(fsm_state), 32'(m_state()));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        cptra_rst_b = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("rst_all_zero", 32'({t1_sts, t2_sts, t1_intr, t2_intr, srv1, srv2, fatal_err, nmi, fsm_state}), 32'd0);
        step();
        cptra_rst_b = 1'b1;
    endtask

    task automatic clear_inputs();
        t1_timeout = 0; t2_timeout = 0; fatal_timeout = 0;
        sts_clr_t1 = 0; sts_clr_t2 = 0;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        cptra_rst_b = 1'b0;
        clear_inputs();
        timer2_en = 1; intr_en_t1 = 1; intr_en_t2 = 1; nmi_delay = 8'd5;
        #1;
        compare_all();
        chk("reset_state", 32'(fsm_state), 32'd0);
        step();
        cptra_rst_b = 1'b1;
        step();

        // Independent mode: set, interrupt, clear, serviced pulse.
        t1_timeout = 1;
        step();
        chk("t1_set_sts", 32'(t1_sts), 32'd1);
        chk("t1_set_intr", 32'(t1_intr), 32'd1);
        sts_clr_t1 = 1;
        step();
        sts_clr_t1 = 0;
        chk("t1_clr_sts", 32'(t1_sts), 32'd0);
        chk("t1_srv_pulse", 32'(srv1), 32'd1);
        chk("t1_clr_intr", 32'(t1_intr), 32'd0);
        step();
        chk("t1_srv_one_cycle", 32'(srv1), 32'd0);

        // Rising edge coinciding with clear: set wins, no pulse.
        t1_timeout = 0;
        step();
        t1_timeout = 1;
        step();
        t1_timeout = 0;
        step();
        t1_timeout = 1; sts_clr_t1 = 1;
        step();
        sts_clr_t1 = 0;
        chk("t1_set_wins", 32'(t1_sts), 32'd1);
        chk("t1_no_srv_on_rise", 32'(srv1), 32'd0);
        sts_clr_t2 = 1;
        step();
        sts_clr_t2 = 0;
        step();
        chk("t2_clr_when_zero_no_pulse", 32'(srv2), 32'd0);

        // Cascade mode: timer2 timeout does not set t2_sts.
        timer2_en = 0; t2_timeout = 1;
        step();
        step();
        chk("cascade_t2_sts", 32'(t2_sts), 32'd0);

        // Fatal path with nmi_delay=5.
        nmi_delay = 8'd5; fatal_timeout = 1;
        step();
        chk("fatal_err_set", 32'(fatal_err), 32'd1);
        chk("fsm_nmi_wait", 32'(fsm_state), 32'd1);
        chk("nmi_not_yet", 32'(nmi), 32'd0);
        for (int i = 1; i < 5; i++) begin
            nmi_delay = 8'(i);
            step();
            chk("nmi_wait_hold", 32'(nmi), 32'd0);
        end
        step();
        chk("nmi_after_5", 32'(nmi), 32'd1);
        chk("fsm_fatal", 32'(fsm_state), 32'd2);
        fatal_timeout = 0; sts_clr_t1 = 1;
        step();
        sts_clr_t1 = 0;
        chk("fatal_sticky", 32'(fatal_err), 32'd1);
        chk("nmi_sticky", 32'(nmi), 32'd1);
        chk("no_srv_in_fatal", 32'(srv1), 32'd0);
        step();

        // nmi_delay=0: fatal_err and nmi together.
        async_reset();
        nmi_delay = 8'd0; fatal_timeout = 1;
        step();
        chk("dly0_fatal", 32'(fatal_err), 32'd1);
        chk("dly0_nmi", 32'(nmi), 32'd1);
        chk("dly0_state", 32'(fsm_state), 32'd2);

        // Reset in NMI_WAIT with three cycles remaining, then restart on a held level.
        async_reset();
        nmi_delay = 8'd5;
        step();
        step();
        step();
        chk("pre_reset_wait", 32'(fsm_state), 32'd1);
        async_reset();
        step();
        chk("restart_fatal", 32'(fatal_err), 32'd1);
        chk("restart_state", 32'(fsm_state), 32'd1);
        for (int i = 0; i < 6; i++) step();
        chk("restart_nmi", 32'(nmi), 32'd1);

        // Randomized traffic.
        async_reset();
        clear_inputs();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) t1_timeout = ~t1_timeout;
            if ($urandom_range(0, 3) == 0) t2_timeout = ~t2_timeout;
            if ($urandom_range(0, 15) == 0) fatal_timeout = ~fatal_timeout;
            if ($urandom_range(0, 31) == 0) timer2_en = ~timer2_en;
            intr_en_t1 = 1'($urandom_range(0, 1));
            intr_en_t2 = 1'($urandom_range(0, 1));
            sts_clr_t1 = ($urandom_range(0, 2) == 0);
            sts_clr_t2 = ($urandom_range(0, 2) == 0);
            nmi_delay  = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 149) == 0) async_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
